// File: rtl/nec_ir_transmitter.sv
// nec_ir_transmitter: Wishbone-controlled NEC infrared envelope generator
// supporting normal frames, repeat codes, output inversion and abort.
module nec_ir_transmitter #(
    parameter int PSIZE = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [31:0] wbs_adr_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        ir_out,
    output logic        irq
);
    typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK} state_t;
    state_t state, state_n;
    logic [2:0]       ctrl;
    logic [PSIZE-1:0] prescaler, psc, pcnt, psc_w;
    logic [16:0]      data, data_w;
    logic [31:0]      sh, mask, rdata;
    logic [4:0]       ucnt, units, bcnt;
    logic             done, overrun, go, rpt;
    logic             req, wr, dwr, swr, busy, tick, last, fin, unused;

    assign req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr     = req & wbs_we_i;
    assign dwr    = wr && wbs_adr_i[3:2] == 2'd2;
    assign swr    = wr && wbs_adr_i[3:2] == 2'd3 && wbs_sel_i[0];
    assign mask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign psc_w  = (prescaler & ~mask[PSIZE-1:0]) | (wbs_dat_i[PSIZE-1:0] & mask[PSIZE-1:0]);
    assign data_w = (data & ~mask[16:0]) | (wbs_dat_i[16:0] & mask[16:0]);
    assign unused = ^{wbs_adr_i, wbs_dat_i, mask};
    assign busy   = state != IDLE;
    assign tick   = pcnt == psc;
    assign last   = tick && ucnt == units - 5'd1;
    assign rdata  = wbs_adr_i[3:2] == 2'd0 ? {29'd0, ctrl} :
                    wbs_adr_i[3:2] == 2'd1 ? 32'(prescaler) :
                    wbs_adr_i[3:2] == 2'd2 ? {15'd0, data} : {29'd0, overrun, done, busy};
    assign ir_out = (state == LEAD_MARK || state == BIT_MARK || state == STOP_MARK) ^ ctrl[1];
    assign irq    = done & ctrl[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        units   = 5'd1;
        fin     = 1'b0;
        case (state)
            IDLE:       state_n = go ? LEAD_MARK : IDLE;
            LEAD_MARK: begin
                units   = 5'd16;
                state_n = last ? LEAD_SPACE : state;
            end
            LEAD_SPACE: begin
                units   = rpt ? 5'd4 : 5'd8;
                state_n = !last ? state : rpt ? STOP_MARK : BIT_MARK;
            end
            BIT_MARK:   state_n = last ? BIT_SPACE : state;
            BIT_SPACE: begin
                units   = sh[0] ? 5'd3 : 5'd1;
                state_n = !last ? state : bcnt == 5'd31 ? STOP_MARK : BIT_MARK;
            end
            STOP_MARK: begin
                state_n = last ? IDLE : state;
                fin     = last;
            end
            default:    state_n = IDLE;
        endcase
        // clearing enable abandons the frame without reporting completion
        if (!ctrl[0]) begin
            state_n = IDLE;
            fin     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc  <= '0;
            pcnt <= '0;
            ucnt <= '0;
            bcnt <= '0;
            sh   <= '0;
            rpt  <= 1'b0;
        end else if (!busy && go) begin
            psc  <= prescaler;
            pcnt <= '0;
            ucnt <= '0;
            bcnt <= '0;
            sh   <= {~data[15:8], data[15:8], ~data[7:0], data[7:0]};
            rpt  <= data[16];
        end else if (busy) begin
            pcnt <= tick ? '0 : pcnt + PSIZE'(1);
            if (tick) ucnt <= last ? 5'd0 : ucnt + 5'd1;
            if (state == BIT_SPACE && last) begin
                sh   <= sh >> 1;
                bcnt <= bcnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            ctrl      <= '0;
            prescaler <= '0;
            data      <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            go        <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
            go        <= dwr && !busy && ctrl[0];
            done      <= fin || (done && !(swr && wbs_dat_i[1]));
            overrun   <= (dwr && busy) || (overrun && !(swr && wbs_dat_i[2]));
            if (wr && wbs_adr_i[3:2] == 2'd0 && wbs_sel_i[0]) ctrl <= wbs_dat_i[2:0];
            if (wr && wbs_adr_i[3:2] == 2'd1) prescaler <= psc_w;
            if (dwr && !busy) data <= data_w;
        end
    end
endmodule
